// File: rtl/twiddle_gen_param_if.sv
// twiddle_gen_param_if: sample strobe/control inputs and registered twiddle outputs
// shared between a twiddle_gen_param stage and whatever drives it.
interface twiddle_gen_param_if #(
    parameter int LOG2N = 5,
    parameter int WIDTH = 24
);
    logic                    in_valid;
    logic                    clr;
    logic                    inverse;
    logic                    out_valid;
    logic signed [WIDTH-1:0] w_r;
    logic signed [WIDTH-1:0] w_i;
    logic [1:0]              state;
    logic [LOG2N-1:0]        idx;
    logic                    frame_end;
    modport master (
        output in_valid, clr, inverse,
        input  out_valid, w_r, w_i, state, idx, frame_end
    );
    modport slave (
        input  in_valid, clr, inverse,
        output out_valid, w_r, w_i, state, idx, frame_end
    );
endinterface

// File: rtl/twiddle_gen_param.sv
// twiddle_gen_param: radix-2 SDF stage twiddle generator; tracks the frame index and
// stage phase and emits W_N^m (or its conjugate) from a quarter-wave cosine ROM.
module twiddle_gen_param #(
    parameter int LOG2N = 5,
    parameter int WIDTH = 24,
    parameter int FRAC  = 8
) (
    input logic                clk,
    input logic                rst_n,
    twiddle_gen_param_if.slave bus
);
    localparam int N  = 1 << LOG2N;
    localparam int Q  = N / 4;
    localparam int AW = LOG2N - 1;
    localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1) << FRAC;
    typedef enum logic [1:0] {PRIME = 2'd0, PASS = 2'd1, ROTATE = 2'd2} phase_t;
    // ROM contents C[i] = round(cos(2*pi*i/N) * 2**FRAC), built from a Taylor series
    function automatic logic signed [WIDTH-1:0] cos_q(input int i);
        real x, term, sum, scale;
        x = 2.0 * 3.14159265358979323846 * i / N;
        term = 1.0;
        sum = 1.0;
        for (int n = 1; n < 16; n++) begin
            term = -term * x * x / ((2 * n - 1) * (2 * n));
            sum = sum + term;
        end
        scale = 1.0;
        for (int f = 0; f < FRAC; f++) scale = scale * 2.0;
        return WIDTH'($rtoi(sum * scale + 0.5));
    endfunction
    logic signed [WIDTH-1:0] w_lut [Q+1];
    for (genvar g = 0; g <= Q; g++) begin : g_lut
        assign w_lut[g] = cos_q(g);
    end
    logic [LOG2N-1:0]        r_k;
    logic                    r_primed;
    logic                    r_inv;
    logic                    r_valid;
    logic                    r_fe;
    phase_t                  r_state;
    logic [LOG2N-1:0]        r_idx;
    logic signed [WIDTH-1:0] r_wr;
    logic signed [WIDTH-1:0] r_wi;
    logic [AW-1:0]           w_m;
    logic [AW-1:0]           w_d;
    logic [AW-1:0]           w_ra;
    logic [AW-1:0]           w_ia;
    logic                    w_hi;
    logic                    w_inv;
    phase_t                  w_state;
    logic signed [WIDTH-1:0] w_c_r;
    logic signed [WIDTH-1:0] w_c_i;
    logic signed [WIDTH-1:0] w_tr;
    logic signed [WIDTH-1:0] w_ti;
    // In ROTATE, m = k - N/2 is simply k with its top bit dropped
    always_comb begin
        w_m     = r_k[AW-1:0];
        w_hi    = w_m > AW'(Q);
        w_d     = w_m - AW'(Q);
        w_ra    = w_hi ? AW'(Q) - w_d : w_m;
        w_ia    = w_hi ? w_d : AW'(Q) - w_m;
        w_c_r   = w_lut[w_ra];
        w_c_i   = w_lut[w_ia];
        w_inv   = (r_k == '0) ? bus.inverse : r_inv;
        w_state = !r_primed ? PRIME : (r_k[LOG2N-1] ? ROTATE : PASS);
        w_tr    = (w_state != ROTATE) ? ONE : (w_hi ? -w_c_r : w_c_r);
        w_ti    = (w_state != ROTATE) ? '0 : (w_inv ? w_c_i : -w_c_i);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_k      <= '0;
            r_primed <= 1'b0;
            r_inv    <= 1'b0;
            r_valid  <= 1'b0;
            r_fe     <= 1'b0;
            r_state  <= PRIME;
            r_idx    <= '0;
            r_wr     <= ONE;
            r_wi     <= '0;
        end else if (bus.clr) begin
            r_k      <= '0;
            r_primed <= 1'b0;
            r_valid  <= 1'b0;
            r_fe     <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            r_fe    <= bus.in_valid && (r_k == '1);
            if (bus.in_valid) begin
                r_k     <= r_k + LOG2N'(1);
                r_inv   <= w_inv;
                r_state <= w_state;
                r_idx   <= r_k;
                r_wr    <= w_tr;
                r_wi    <= w_ti;
                if (r_k == LOG2N'(N / 2 - 1)) r_primed <= 1'b1;
            end
        end
    end
    assign bus.out_valid = r_valid;
    assign bus.frame_end = r_fe;
    assign bus.state     = r_state;
    assign bus.idx       = r_idx;
    assign bus.w_r       = r_wr;
    assign bus.w_i       = r_wi;
endmodule

// File: tb/tb_twiddle_gen_param.sv
// tb_twiddle_gen_param: scoreboard bench for the N=32, FRAC=8 twiddle generator using
// the hand-rounded quarter-wave table 256,251,237,213,181,142,98,50,0.
module tb_twiddle_gen_param;
    typedef struct {
        int idx;
        int st;
        int wr;
        int wi;
        int fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];
    exp_t last;
    int   tk = 0;
    bit   tprimed = 1'b0;
    bit   tinv = 1'b0;
    int   ctab[9] = '{256, 251, 237, 213, 181, 142, 98, 50, 0};

    twiddle_gen_param_if #(.LOG2N(5), .WIDTH(24)) bus ();
    twiddle_gen_param #(.LOG2N(5), .WIDTH(24), .FRAC(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, longint got, longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic exp_t model(int k, bit primed, bit inv);
        exp_t e;
        int m, d;
        e.idx = k;
        e.fe  = (k == 31) ? 1 : 0;
        e.st  = !primed ? 0 : (k < 16 ? 1 : 2);
        e.wr  = 256;
        e.wi  = 0;
        if (e.st == 2) begin
            m = k - 16;
            if (m <= 8) begin
                e.wr = ctab[m];
                e.wi = -ctab[8 - m];
            end else begin
                d = m - 8;
                e.wr = -ctab[8 - d];
                e.wi = -ctab[d];
            end
            if (inv) e.wi = -e.wi;
        end
        return e;
    endfunction

    task automatic step(bit v, bit c, bit inv);
        exp_t e;
        bit   iu;
        bus.in_valid = v;
        bus.clr      = c;
        bus.inverse  = inv;
        if (c) begin
            tk = 0;
            tprimed = 1'b0;
        end else if (v) begin
            iu = (tk == 0) ? inv : tinv;
            e = model(tk, tprimed, iu);
            q.push_back(e);
            last = e;
            if (tk == 15) tprimed = 1'b1;
            tk = (tk + 1) % 32;
            tinv = iu;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(int n, bit inv);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, inv);
    endtask

    task automatic check_hold();
        chk("gap_out_valid", bus.out_valid, 0);
        chk("gap_frame_end", bus.frame_end, 0);
        chk("gap_idx", bus.idx, last.idx);
        chk("gap_state", bus.state, last.st);
        chk("gap_w_r", bus.w_r, last.wr);
        chk("gap_w_i", bus.w_i, last.wi);
    endtask

    task automatic do_reset(bit v);
        rst_n = 1'b0;
        bus.in_valid = v;
        bus.clr = 1'b0;
        bus.inverse = 1'b0;
        tk = 0;
        tprimed = 1'b0;
        tinv = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_frame_end", bus.frame_end, 0);
        chk("rst_state", bus.state, 0);
        chk("rst_idx", bus.idx, 0);
        chk("rst_w_r", bus.w_r, 256);
        chk("rst_w_i", bus.w_i, 0);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("idx", bus.idx, e.idx);
                chk("state", bus.state, e.st);
                chk("w_r", bus.w_r, e.wr);
                chk("w_i", bus.w_i, e.wi);
                chk("frame_end", bus.frame_end, e.fe);
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.clr = 1'b0;
        bus.inverse = 1'b0;
        do_reset(1'b0);
        run(32, 1'b0);
        run(32, 1'b0);
        run(5, 1'b0);
        run(27, 1'b1);
        run(32, 1'b1);
        run(8, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_hold();
        step(1'b0, 1'b0, 1'b0);
        check_hold();
        step(1'b1, 1'b0, 1'b0);
        run(10, 1'b0);
        chk("pre_clr_k", tk, 20);
        step(1'b1, 1'b1, 1'b0);
        chk("clr_out_valid", bus.out_valid, 0);
        run(11, 1'b0);
        do_reset(1'b1);
        run(20, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
